bus_tenure_ctrl: RTL
====================

BUS_TENURE_CTRL -- requirements
Module: bus_tenure_ctrl

Interface
REQ-001 SHALL provide parameter NUMUNITS, default 8: number of requesting units.
REQ-002 SHALL provide parameter ADDRESSWIDTH, default 3: bits needed to index NUMUNITS.
REQ-003 SHALL provide parameter BURSTWIDTH, default 4: bits per unit burst-length field.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port request  input  NUMUNITS  raw unit requests.
REQ-007 SHALL have port release  input  NUMUNITS  per-unit early-release strobes.
REQ-008 SHALL have port burst_len  input  BURSTWIDTH*NUMUNITS  packed per-unit length; unit i occupies bits [i*BURSTWIDTH +: BURSTWIDTH].
REQ-009 SHALL have port grant  input  NUMUNITS  registered grant vector from the upstream arbiter.
REQ-010 SHALL have port arb_request  output  NUMUNITS  gated requests driven to the arbiter.
REQ-011 SHALL have port owner  output  ADDRESSWIDTH  index of the current bus owner.
REQ-012 SHALL have port owner_valid  output  1  high while a tenure is active.
REQ-013 SHALL have port beat  output  1  high on each data-beat cycle of the owner.
REQ-014 SHALL have port beat_index  output  BURSTWIDTH  zero-based index of the current beat.
REQ-015 SHALL have port tenure_done  output  1  one-cycle pulse on the last cycle of a tenure.
REQ-016 SHALL have port grant_error  output  1  one-cycle pulse when grant is multi-hot.
REQ-017 SHALL have port starve  output  1  sticky starvation flag (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, OWN, GAP; all outputs registered except arb_request.
REQ-019 In IDLE, arb_request SHALL equal request; in OWN and GAP, arb_request SHALL be all zeros.
REQ-020 In IDLE, a one-hot grant at edge N SHALL capture owner = index of the set bit, set owner_valid, beat = 1 and beat_index = 0, and load remaining = burst_len[owner], all visible after edge N (cycle N+1); state -> OWN.
REQ-021 A burst_len value L SHALL give L+1 beats (0 -> one beat; max 2^BURSTWIDTH beats).
REQ-022 In OWN, each cycle SHALL assert beat; beat_index SHALL increment by 1 per cycle and remaining SHALL decrement by 1 per cycle.
REQ-023 The tenure SHALL end on the cycle where remaining == 0, release[owner] == 1, or request[owner] == 0; that cycle SHALL be the last beat, with tenure_done = 1 for exactly one cycle.
REQ-024 Simultaneous end conditions SHALL produce a single tenure_done pulse.
REQ-025 After the end cycle, the FSM SHALL enter GAP for exactly one cycle (owner_valid = 0, beat = 0), then return to IDLE.
REQ-026 Grants arriving in OWN or GAP SHALL be ignored; release bits of non-owners SHALL be ignored.
REQ-027 A multi-hot grant in IDLE SHALL pulse grant_error for one cycle; the FSM SHALL remain in IDLE and capture nothing.
REQ-028 An all-zero grant in IDLE SHALL leave the FSM in IDLE.
REQ-029 owner SHALL hold its last value outside OWN; beat_index SHALL be 0 outside OWN.

Reset
REQ-030 Asserting reset (low) SHALL immediately force IDLE with owner = 0, owner_valid = 0, beat = 0, beat_index = 0, tenure_done = 0, grant_error = 0, starve = 0, and internal counters = 0, including mid-tenure.
REQ-031 After reset deasserts, the first capture SHALL be able to occur at the next rising edge with a valid grant.

Configuration
REQ-032 Macro TENURE_STARVE_EN defined: an 8-bit counter SHALL increment each IDLE cycle with request != 0 and grant == 0, and SHALL clear on any capture.
REQ-033 With TENURE_STARVE_EN, starve SHALL be set when the counter reaches 255 and SHALL stay set until reset.
REQ-034 Macro TENURE_STARVE_EN undefined: no counter SHALL be built, and starve SHALL be tied to 0.

Verification
REQ-035 Verification SHALL cover: request = 8'h04, grant = 8'h04 at edge N, burst_len[2] = 3 -> owner = 2, four beats with beat_index 0..3, tenure_done on the fourth beat, GAP, then IDLE.
REQ-036 Verification SHALL cover: owner 5, burst_len = 15, release[5] pulsed on the third beat -> tenure ends on beat_index 2; release[1] at any time has no effect.
REQ-037 Verification SHALL cover: grant = 8'h0A in IDLE -> grant_error pulses once, owner_valid stays 0, arb_request still equals request.
REQ-038 Verification SHALL cover: reset asserted on the second beat of an 8-beat tenure -> all outputs zero without waiting for a clock edge; after release, grant = 8'h01 captures owner 0.
REQ-039 Verification SHALL cover: with TENURE_STARVE_EN, request = 8'h80 and grant held at 0 for 255 IDLE cycles -> starve = 1 and it remains 1; without the macro, starve stays 0.
REQ-040 Verification SHALL cover: burst_len = 0 with release and request dropping on the same cycle -> one beat, a single tenure_done pulse.

Source files
------------

// File: rtl/bus_tenure_ctrl.sv
// bus_tenure_ctrl
//   Bus tenure controller that sits behind an upstream arbiter. While idle it
//   forwards unit requests to the arbiter and waits for a grant. A one-hot
//   grant opens a tenure for the granted unit. A multi-hot grant raises a
//   one-cycle error and opens nothing. A tenure issues one data beat per
//   cycle until the programmed burst is exhausted, the owner releases early,
//   or the owner drops its request. After the last beat there is one gap
//   cycle, and then the controller returns to idle.
//
//   Optional feature: define TENURE_STARVE_EN to build an 8-bit starvation
//   counter that drives the sticky starve flag. With the macro undefined,
//   starve is tied low and no counter is built.
//
// Parameters
//   NUMUNITS      number of requesting units
//   ADDRESSWIDTH  bits needed to index NUMUNITS
//   BURSTWIDTH    bits per unit burst-length field
//
// Ports
//   clock         sole clock, rising edge
//   reset         asynchronous, active-low reset
//   request       raw unit requests
//   early_release per-unit early-release strobes ("release" is a reserved
//                 word, so the port carries this name)
//   burst_len     packed per-unit burst length; unit i uses [i*BURSTWIDTH +: BURSTWIDTH]
//                 a length of L produces L+1 beats
//   grant         registered grant vector from the arbiter
//   arb_request   gated requests to the arbiter (combinational)
//   owner         index of the current or most recent bus owner
//   owner_valid   high while a tenure is active
//   beat          high on each data-beat cycle
//   beat_index    zero-based beat number, 0 outside a tenure
//   tenure_done   high on the last beat of a tenure
//   grant_error   one-cycle pulse after a multi-hot grant in idle
//   starve        sticky starvation flag
module bus_tenure_ctrl #(
  parameter int NUMUNITS     = 8,
  parameter int ADDRESSWIDTH = 3,
  parameter int BURSTWIDTH   = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUMUNITS-1:0]            request,
  input  logic [NUMUNITS-1:0]            early_release,
  input  logic [BURSTWIDTH*NUMUNITS-1:0] burst_len,
  input  logic [NUMUNITS-1:0]            grant,
  output logic [NUMUNITS-1:0]            arb_request,
  output logic [ADDRESSWIDTH-1:0]        owner,
  output logic                           owner_valid,
  output logic                           beat,
  output logic [BURSTWIDTH-1:0]          beat_index,
  output logic                           tenure_done,
  output logic                           grant_error,
  output logic                           starve
);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t                  state, state_nx;
  logic [BURSTWIDTH-1:0]   remaining, remaining_nx;
  logic [ADDRESSWIDTH-1:0] owner_nx;
  logic                    owner_valid_nx, beat_nx, tenure_done_nx, grant_error_nx;
  logic [BURSTWIDTH-1:0]   beat_index_nx;

  logic                    grant_any, grant_onehot, capture;
  logic [ADDRESSWIDTH-1:0] grant_idx;
  logic [BURSTWIDTH-1:0]   cap_len;

  // Grant decode: index and burst length of the granted unit. These values
  // are used only when the grant is one-hot.
  always_comb begin
    grant_any    = |grant;
    grant_onehot = grant_any && ((grant & (grant - NUMUNITS'(1))) == '0);
    grant_idx    = '0;
    cap_len      = '0;
    for (int unsigned i = 0; i < NUMUNITS; i++) begin
      if (grant[i]) begin
        grant_idx = ADDRESSWIDTH'(i);
        cap_len   = burst_len[i*BURSTWIDTH +: BURSTWIDTH];
      end
    end
  end

  assign capture     = (state == IDLE) && grant_onehot;
  assign arb_request = (state == IDLE) ? request : '0;

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      remaining   <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      beat        <= 1'b0;
      beat_index  <= '0;
      tenure_done <= 1'b0;
      grant_error <= 1'b0;
    end else begin
      state       <= state_nx;
      remaining   <= remaining_nx;
      owner       <= owner_nx;
      owner_valid <= owner_valid_nx;
      beat        <= beat_nx;
      beat_index  <= beat_index_nx;
      tenure_done <= tenure_done_nx;
      grant_error <= grant_error_nx;
    end
  end

  // Next state. The registered tenure_done marks the beat being presented as
  // the final one, so the controller leaves OWN after that beat.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (capture) state_nx = OWN;
      OWN:     if (tenure_done) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next registered outputs. The end condition is evaluated at the edge that
  // starts a beat: the remaining count for that beat, plus release and
  // request sampled at that edge. This lets the final beat carry tenure_done,
  // and simultaneous causes still produce a single pulse.
  always_comb begin
    owner_nx       = owner;
    owner_valid_nx = 1'b0;
    beat_nx        = 1'b0;
    beat_index_nx  = '0;
    tenure_done_nx = 1'b0;
    grant_error_nx = 1'b0;
    remaining_nx   = remaining;
    case (state)
      IDLE: begin
        if (capture) begin
          owner_nx       = grant_idx;
          owner_valid_nx = 1'b1;
          beat_nx        = 1'b1;
          remaining_nx   = cap_len;
          tenure_done_nx = (cap_len == '0) || early_release[grant_idx] || !request[grant_idx];
        end else if (grant_any) begin
          grant_error_nx = 1'b1;
        end
      end
      OWN: begin
        if (tenure_done) begin
          remaining_nx = '0;
        end else begin
          owner_valid_nx = 1'b1;
          beat_nx        = 1'b1;
          beat_index_nx  = beat_index + BURSTWIDTH'(1);
          remaining_nx   = remaining - BURSTWIDTH'(1);
          tenure_done_nx = (remaining == BURSTWIDTH'(1)) || early_release[owner] || !request[owner];
        end
      end
      default: ;
    endcase
  end

`ifdef TENURE_STARVE_EN
  logic [7:0] starve_cnt, starve_cnt_nx;

  // Counts idle cycles in which units are waiting and no grant arrives.
  // The count saturates at 255 and clears on any capture.
  always_comb begin
    starve_cnt_nx = starve_cnt;
    if (capture) begin
      starve_cnt_nx = '0;
    end else if ((state == IDLE) && (|request) && !grant_any && (starve_cnt != '1)) begin
      starve_cnt_nx = starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nx;
      if (starve_cnt_nx == '1) starve <= 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

endmodule
